line_fill_req: RTL and testbench

- Bus-master miss agent sitting directly upstream of the ROM and memory fill responders.
- Accepts one line-miss request from the instruction/data cache and issues CMD_BUSRD or CMD_BUSRDX on the slotted system bus.
- Retries on nack, then collects the 8 CMD_FILL beats carrying its tag into a 64-byte line buffer.
- Hands the completed line back to the cache over a valid/ready handshake.

---
 rtl/line_fill_req_if.sv | 68 ++++++
 rtl/line_fill_req.sv | 218 +++++++++++++++++++++
 tb/tb_line_fill_req.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_req_if.sv
// line_fill_req_if -- signal bundle for the line fill request agent.
//
// Groups the cache-side request/response handshakes, the broadcast bus
// inputs, the agent's bus drive outputs and the debug observation signals.
//
//   req_*      : cache -> agent miss request (valid/ready)
//   resp_*     : agent -> cache filled line (valid/ready)
//   bus_*      : broadcast slotted system bus, seen by every agent
//   lfr_bus_*  : what this agent drives onto the bus
//   bus_lfr_grant : arbiter grant for the next frame
//   dbg_*      : FSM state and cumulative retry count
//
// Handshake rule for req and resp: a transfer happens on a rising clk edge
// where valid and ready are both 1; once valid rises it stays high and its
// payload stays stable until that edge.
//
// Modports:
//   master : the agent itself (line_fill_req)
//   slave  : the environment (cache + bus fabric)
`timescale 1ns/1ps
interface line_fill_req_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_excl;
  logic [25:0]  req_addr;

  logic         resp_valid;
  logic         resp_ready;
  logic [25:0]  resp_addr;
  logic [511:0] resp_data;

  logic         bus_valid;
  logic         bus_nack;
  logic         bus_hit;
  logic [2:0]   bus_cmd;
  logic [4:0]   bus_tag;
  logic [29:0]  bus_addr;
  logic [63:0]  bus_data;

  logic         lfr_bus_req;
  logic [2:0]   lfr_bus_cmd;
  logic [4:0]   lfr_bus_tag;
  logic [29:0]  lfr_bus_addr;
  logic [63:0]  lfr_bus_data;
  logic         lfr_bus_nack;
  logic         bus_lfr_grant;

  logic [2:0]   dbg_state;
  logic [7:0]   dbg_retry_cnt;

  modport master (
    input  req_valid, req_excl, req_addr, resp_ready,
           bus_valid, bus_nack, bus_hit, bus_cmd, bus_tag, bus_addr, bus_data,
           bus_lfr_grant,
    output req_ready, resp_valid, resp_addr, resp_data,
           lfr_bus_req, lfr_bus_cmd, lfr_bus_tag, lfr_bus_addr, lfr_bus_data,
           lfr_bus_nack, dbg_state, dbg_retry_cnt
  );

  modport slave (
    output req_valid, req_excl, req_addr, resp_ready,
           bus_valid, bus_nack, bus_hit, bus_cmd, bus_tag, bus_addr, bus_data,
           bus_lfr_grant,
    input  req_ready, resp_valid, resp_addr, resp_data,
           lfr_bus_req, lfr_bus_cmd, lfr_bus_tag, lfr_bus_addr, lfr_bus_data,
           lfr_bus_nack, dbg_state, dbg_retry_cnt
  );
endinterface

// File: rtl/line_fill_req.sv
// line_fill_req -- bus-master miss agent.
//
// Takes one line-miss request from the cache, issues BUSRD/BUSRDX on the
// 8-cycle slotted bus, retries on nack, gathers the 8 FILL beats that carry
// AGENT_TAG into a 64-byte line and returns the line to the cache.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   lf    : line_fill_req_if.master (request, response, bus, debug)
//
// Parameters:
//   AGENT_TAG : tag placed on commands and matched on fills
//   TIMEOUT   : WAIT cycles allowed before the first fill beat
//
// Optional feature macro FILL_TIMEOUT_EN: when defined, a WAIT that sees no
// beat within TIMEOUT cycles re-arbitrates and reissues the same command.
// When undefined, WAIT is unbounded and the timeout counter does not exist.
//
// FSM: IDLE -> ARB -> CMD -> (nack: ARB | ok: WAIT) -> DONE -> IDLE
`timescale 1ns/1ps
module line_fill_req #(
  parameter logic [4:0] AGENT_TAG = 5'd1,
  parameter int         TIMEOUT   = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  line_fill_req_if.master lf
);

  // Bus command encodings shared with every other agent on the bus.
  localparam logic [2:0] CMD_BUSRD  = 3'd1;
  localparam logic [2:0] CMD_BUSRDX = 3'd2;
  localparam logic [2:0] CMD_FILL   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_CMD  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bus_cycle_q;
  logic [25:0]     addr_q, addr_d;
  logic            excl_q, excl_d;
  logic            breq_q, breq_d;
  logic [2:0]      bcmd_q, bcmd_d;
  logic [4:0]      btag_q, btag_d;
  logic [29:0]     baddr_q, baddr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [25:0]     resp_addr_q, resp_addr_d;
  logic [7:0][63:0] line_q;
  logic [2:0]      beat_q, beat_d;
  logic            beat_we;
  logic [7:0]      retry_q, retry_d;
  logic [7:0]      retry_inc;
  logic            beat_hit;

`ifdef FILL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]     to_q, to_d;
`endif

  // A fill beat counts only in the frame slot matching the next expected
  // beat, so a fill stream that starts mid-frame is skipped until it lines up.
  assign beat_hit = lf.bus_valid && (lf.bus_cmd == CMD_FILL) &&
                    (lf.bus_tag == AGENT_TAG) && (bus_cycle_q == beat_q);

  assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-register values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    excl_d       = excl_q;
    breq_d       = breq_q;
    bcmd_d       = bcmd_q;
    btag_d       = btag_q;
    baddr_d      = baddr_q;
    resp_valid_d = resp_valid_q;
    resp_addr_d  = resp_addr_q;
    beat_d       = beat_q;
    beat_we      = 1'b0;
    retry_d      = retry_q;
`ifdef FILL_TIMEOUT_EN
    to_d         = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (lf.req_valid) begin
          addr_d  = lf.req_addr;
          excl_d  = lf.req_excl;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        // Request is raised at frame start; the arbiter answers at cycle 7
        // for the following frame.
        if (bus_cycle_q == 3'd0) begin
          breq_d = 1'b1;
          bcmd_d = excl_q ? CMD_BUSRDX : CMD_BUSRD;
        end
        if ((bus_cycle_q == 3'd7) && breq_q && lf.bus_lfr_grant) begin
          btag_d  = AGENT_TAG;
          baddr_d = {addr_q, 4'b0000};
          breq_d  = 1'b0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        // Command is on the bus for this single cycle only.
        bcmd_d  = 3'd0;
        btag_d  = 5'd0;
        baddr_d = 30'd0;
        if (lf.bus_nack) begin
          retry_d = retry_inc;
          state_d = S_ARB;
        end else begin
          state_d = S_WAIT;
`ifdef FILL_TIMEOUT_EN
          to_d    = 16'd0;
`endif
        end
      end
      S_WAIT: begin
`ifdef FILL_TIMEOUT_EN
        to_d = to_q + 16'd1;
`endif
        if (beat_hit) begin
          beat_we = 1'b1;
          if (beat_q == 3'd7) begin
            beat_d       = 3'd0;
            resp_valid_d = 1'b1;
            resp_addr_d  = addr_q;
            state_d      = S_DONE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
`ifdef FILL_TIMEOUT_EN
        // Timeout only while nothing has arrived; a started fill is trusted
        // to finish.
        else if ((beat_q == 3'd0) && (to_q == TO_LAST)) begin
          retry_d = retry_inc;
          to_d    = 16'd0;
          state_d = S_ARB;
        end
`endif
      end
      S_DONE: begin
        if (lf.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_cycle_q  <= 3'd0;
      addr_q       <= 26'd0;
      excl_q       <= 1'b0;
      breq_q       <= 1'b0;
      bcmd_q       <= 3'd0;
      btag_q       <= 5'd0;
      baddr_q      <= 30'd0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= 26'd0;
      line_q       <= '0;
      beat_q       <= 3'd0;
      retry_q      <= 8'd0;
`ifdef FILL_TIMEOUT_EN
      to_q         <= 16'd0;
`endif
    end else begin
      bus_cycle_q  <= bus_cycle_q + 3'd1;
      addr_q       <= addr_d;
      excl_q       <= excl_d;
      breq_q       <= breq_d;
      bcmd_q       <= bcmd_d;
      btag_q       <= btag_d;
      baddr_q      <= baddr_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      beat_q       <= beat_d;
      retry_q      <= retry_d;
`ifdef FILL_TIMEOUT_EN
      to_q         <= to_d;
`endif
      if (beat_we) line_q[beat_q] <= lf.bus_data;
    end
  end

  assign lf.req_ready     = (state_q == S_IDLE);
  assign lf.resp_valid    = resp_valid_q;
  assign lf.resp_addr     = resp_addr_q;
  assign lf.resp_data     = line_q;
  assign lf.lfr_bus_req   = breq_q;
  assign lf.lfr_bus_cmd   = bcmd_q;
  assign lf.lfr_bus_tag   = btag_q;
  assign lf.lfr_bus_addr  = baddr_q;
  assign lf.lfr_bus_data  = 64'd0;
  assign lf.lfr_bus_nack  = 1'b0;
  assign lf.dbg_state     = state_q;
  assign lf.dbg_retry_cnt = retry_q;

endmodule

// File: tb/tb_line_fill_req.sv
// tb_line_fill_req -- directed self-checking bench for line_fill_req.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge. tb_cyc counts rising edges since reset release,
// so tb_cyc[2:0] is the expected bus_cycle.
`timescale 1ns/1ps
module tb_line_fill_req;

  localparam logic [2:0] CMD_BUSRD  = 3'd1;
  localparam logic [2:0] CMD_BUSRDX = 3'd2;
  localparam logic [2:0] CMD_FILL   = 3'd4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARB  = 3'd1;
  localparam logic [2:0] ST_CMD  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

`ifdef FILL_TIMEOUT_EN
  localparam int TB_TIMEOUT = 32;
`else
  localparam int TB_TIMEOUT = 256;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end
  wire [2:0] tb_bc = tb_cyc[2:0];

  line_fill_req_if lf();

  line_fill_req #(.AGENT_TAG(5'd1), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lf    (lf)
  );

  int checks = 0;
  int errors = 0;
  int unsigned c_prev;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fill_word(input int kind, input int i);
    logic [31:0] w;
    w = i;
    case (kind)
      0:       return {w, w};
      1:       return 64'hDEAD_BEEF_0000_0000 + 64'(i);
      2:       return 64'hA5A5_0000_5A5A_0000 + 64'(i);
      default: return 64'h1111_2222_3333_0000 + 64'(i);
    endcase
  endfunction

  function automatic logic [511:0] exp_line(input int kind);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = fill_word(kind, i);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    lf.bus_valid = 1'b0;
    lf.bus_cmd   = 3'd0;
    lf.bus_tag   = 5'd0;
    lf.bus_addr  = 30'd0;
    lf.bus_data  = 64'd0;
  endtask

  task automatic drive_beat(input logic [4:0] tag, input int kind, input int i);
    lf.bus_valid = 1'b1;
    lf.bus_cmd   = CMD_FILL;
    lf.bus_tag   = tag;
    lf.bus_addr  = 30'h3000_0000 + 30'(i);
    lf.bus_data  = fill_word(kind, i);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (lf.dbg_state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, lf.dbg_state, s);
  endtask

  // Fill frame starting at the next bus_cycle 0; returns on the falling edge
  // of the cycle after the last beat with the bus idle again.
  task automatic send_frame(input logic [4:0] tag, input int kind, input int nbeats);
    int n = 0;
    while (tb_bc != 3'd0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < nbeats; i++) begin
      if (i == 7) check("resp_early", lf.resp_valid, 1'b0);
      drive_beat(tag, kind, i);
      @(negedge clk);
    end
    idle_bus();
  endtask

  task automatic request(input logic [25:0] a, input logic x, input string tag);
    check(tag, lf.req_ready, 1'b1);
    lf.req_valid = 1'b1;
    lf.req_addr  = a;
    lf.req_excl  = x;
    @(negedge clk);
    lf.req_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    lf.resp_ready = 1'b1;
    @(negedge clk);
    lf.resp_ready = 1'b0;
    check({tag, "_valid_clr"}, lf.resp_valid, 1'b0);
    check({tag, "_idle"}, lf.dbg_state, ST_IDLE);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     lf.dbg_state, ST_IDLE);
    check({tag, "_req_ready"}, lf.req_ready, 1'b1);
    check({tag, "_bus_req"},   lf.lfr_bus_req, 1'b0);
    check({tag, "_bus_cmd"},   lf.lfr_bus_cmd, 3'd0);
    check({tag, "_bus_tag"},   lf.lfr_bus_tag, 5'd0);
    check({tag, "_bus_addr"},  lf.lfr_bus_addr, 30'd0);
    check({tag, "_resp_vld"},  lf.resp_valid, 1'b0);
    check({tag, "_resp_addr"}, lf.resp_addr, 26'd0);
    check({tag, "_resp_data"}, lf.resp_data, 512'd0);
    check({tag, "_retry"},     lf.dbg_retry_cnt, 8'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_bus();
    lf.bus_nack      = 1'b0;
    lf.bus_hit       = 1'b0;
    lf.bus_lfr_grant = 1'b0;
    lf.req_valid     = 1'b0;
    lf.req_excl      = 1'b0;
    lf.req_addr      = 26'd0;
    lf.resp_ready    = 1'b0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);

    check_reset_outputs("rst");
    check("rst_bus_data", lf.lfr_bus_data, 64'd0);
    check("rst_bus_nack", lf.lfr_bus_nack, 1'b0);

    // Basic read: request in cycle 0, bus_req raised at cycle 8, grant at
    // cycle 15, command in cycle 16, fill frame in cycles 24..31.
    lf.bus_lfr_grant = 1'b1;
    rst_n = 1'b1;
    request(26'h0400000, 1'b0, "basic_req_ready");
    check("basic_arb", lf.dbg_state, ST_ARB);
    check("basic_no_req_yet", lf.lfr_bus_req, 1'b0);
    repeat (8) @(negedge clk);
    check("basic_bus_req", lf.lfr_bus_req, 1'b1);
    check("basic_bus_cmd_arb", lf.lfr_bus_cmd, CMD_BUSRD);
    wait_state(ST_CMD, 16, "basic_cmd_state");
    check("basic_cmd_cycle", tb_cyc, 16);
    check("basic_cmd", lf.lfr_bus_cmd, CMD_BUSRD);
    check("basic_tag", lf.lfr_bus_tag, 5'd1);
    check("basic_addr", lf.lfr_bus_addr, 30'h0400_0000);
    check("basic_req_clr", lf.lfr_bus_req, 1'b0);
    @(negedge clk);
    check("basic_wait", lf.dbg_state, ST_WAIT);
    check("basic_cmd_off", lf.lfr_bus_cmd, 3'd0);
    send_frame(5'd1, 0, 8);
    check("basic_resp_cycle", tb_cyc, 32);
    check("basic_resp_valid", lf.resp_valid, 1'b1);
    check("basic_resp_addr", lf.resp_addr, 26'h0400000);
    check("basic_resp_data", lf.resp_data, exp_line(0));
    check("basic_req_ready_done", lf.req_ready, 1'b0);
    handshake("basic");

    // Exclusive read, nacked twice; commands 16 cycles apart.
    request(26'h1234567, 1'b1, "excl_req_ready");
    for (int k = 0; k < 3; k++) begin
      wait_state(ST_CMD, 40, "excl_cmd_state");
      check("excl_cmd", lf.lfr_bus_cmd, CMD_BUSRDX);
      check("excl_cmd_addr", lf.lfr_bus_addr, {26'h1234567, 4'b0000});
      check("excl_cmd_slot", tb_bc, 3'd0);
      if (k > 0) check("excl_cmd_spacing", tb_cyc - c_prev, 16);
      c_prev = tb_cyc;
      lf.bus_nack = (k < 2);
      lf.bus_hit  = (k == 2);
      @(negedge clk);
      lf.bus_nack = 1'b0;
      lf.bus_hit  = 1'b0;
      check("excl_after_cmd", lf.dbg_state, (k < 2) ? ST_ARB : ST_WAIT);
    end
    check("excl_retry", lf.dbg_retry_cnt, 8'd2);

    // Own tag in the wrong slot, then a whole foreign frame: both ignored.
    while (tb_bc != 3'd3) @(negedge clk);
    lf.bus_valid = 1'b1;
    lf.bus_cmd   = CMD_FILL;
    lf.bus_tag   = 5'd1;
    lf.bus_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    idle_bus();
    send_frame(5'd3, 1, 8);
    check("foreign_state", lf.dbg_state, ST_WAIT);
    check("foreign_no_resp", lf.resp_valid, 1'b0);
    send_frame(5'd1, 2, 8);
    check("excl_resp_valid", lf.resp_valid, 1'b1);
    check("excl_resp_addr", lf.resp_addr, 26'h1234567);
    check("excl_resp_data", lf.resp_data, exp_line(2));

    // Backpressure with a second request already waiting.
    lf.req_valid = 1'b1;
    lf.req_addr  = 26'h2ABCDEF;
    lf.req_excl  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", lf.resp_valid, 1'b1);
      check("bp_data", lf.resp_data, exp_line(2));
      check("bp_addr", lf.resp_addr, 26'h1234567);
      check("bp_req_ready", lf.req_ready, 1'b0);
      @(negedge clk);
    end
    lf.resp_ready = 1'b1;
    @(negedge clk);
    lf.resp_ready = 1'b0;
    check("bp_idle", lf.dbg_state, ST_IDLE);
    check("bp_valid_clr", lf.resp_valid, 1'b0);
    check("bp_req_ready_idle", lf.req_ready, 1'b1);
    @(negedge clk);
    lf.req_valid = 1'b0;
    check("bp_second_accepted", lf.dbg_state, ST_ARB);
    check("bp_req_ready_arb", lf.req_ready, 1'b0);
    check("excl_retry_hold", lf.dbg_retry_cnt, 8'd2);

    // Reset abort after beat 3 of the second request's fill.
    wait_state(ST_CMD, 40, "abort_cmd_state");
    check("abort_cmd", lf.lfr_bus_cmd, CMD_BUSRD);
    check("abort_addr", lf.lfr_bus_addr, {26'h2ABCDEF, 4'b0000});
    send_frame(5'd1, 3, 4);
    check("abort_pre_state", lf.dbg_state, ST_WAIT);
    rst_n = 1'b0;
    drive_beat(5'd1, 3, 4);
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    drive_beat(5'd1, 3, 5);
    @(negedge clk);
    rst_n = 1'b1;
    drive_beat(5'd1, 3, 6);
    @(negedge clk);
    drive_beat(5'd1, 3, 7);
    @(negedge clk);
    idle_bus();
    check("abort_post_state", lf.dbg_state, ST_IDLE);
    check("abort_post_valid", lf.resp_valid, 1'b0);
    check("abort_post_data", lf.resp_data, 512'd0);

    request(26'h0000001, 1'b1, "abort_new_req");
    wait_state(ST_CMD, 40, "abort_new_cmd_state");
    check("abort_new_cmd", lf.lfr_bus_cmd, CMD_BUSRDX);
    check("abort_new_addr", lf.lfr_bus_addr, 30'h10);
    @(negedge clk);
    send_frame(5'd1, 3, 8);
    check("abort_new_valid", lf.resp_valid, 1'b1);
    check("abort_new_addr_resp", lf.resp_addr, 26'h0000001);
    check("abort_new_data", lf.resp_data, exp_line(3));
    check("abort_new_retry", lf.dbg_retry_cnt, 8'd0);
    handshake("abort_new");

`ifdef FILL_TIMEOUT_EN
    // No fill after the command: 32 WAIT cycles, then re-request at the next
    // frame start (cycle c+40, visible c+41) and reissue at c+48.
    request(26'h0155555, 1'b0, "to_req_ready");
    wait_state(ST_CMD, 40, "to_cmd_state");
    c_prev = tb_cyc;
    @(negedge clk);
    check("to_wait", lf.dbg_state, ST_WAIT);
    wait_state(ST_ARB, 60, "to_arb");
    check("to_retry", lf.dbg_retry_cnt, 8'd1);
    while (tb_cyc - c_prev < 40) @(negedge clk);
    check("to_no_req_yet", lf.lfr_bus_req, 1'b0);
    @(negedge clk);
    check("to_rereq", lf.lfr_bus_req, 1'b1);
    wait_state(ST_CMD, 16, "to_cmd2_state");
    check("to_cmd2_cycle", tb_cyc - c_prev, 48);
    check("to_cmd2", lf.lfr_bus_cmd, CMD_BUSRD);
    @(negedge clk);
    send_frame(5'd1, 0, 8);
    check("to_resp_valid", lf.resp_valid, 1'b1);
    check("to_resp_data", lf.resp_data, exp_line(0));
    handshake("to");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
